mul_share_arbiter: RTL and testbench



---
 rtl/mul_share_arbiter.sv | 99 +++++++++
 tb/tb_mul_share_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one pipelined multiplier among NUM_REQ requesters
module mul_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_MUL = WIDTH_A + WIDTH_B,
  parameter int LATENCY   = 2,
  localparam int ID_W     = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W    = $clog2(LATENCY + 2)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH_A-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH_B-1:0]   req_b,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [WIDTH_MUL-1:0]         resp_data,
  output logic                         mul_pip_en,
  output logic [WIDTH_A-1:0]           mul_a,
  output logic [WIDTH_B-1:0]           mul_b,
  input  logic [WIDTH_MUL-1:0]         mul_out,
  output logic [CNT_W-1:0]             inflight,
  output logic                         busy
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt;
  logic            accept;
  logic            head_v;
  logic [ID_W-1:0] head_id;

  function automatic logic [ID_W-1:0] wrap(input int v);
    return ID_W'(v % NUM_REQ);
  endfunction

  // a stalled result register freezes the whole pipe so nothing is dropped
  assign mul_pip_en = !resp_valid || resp_ready;
  assign accept     = mul_pip_en && |req_valid;
  assign req_ready  = accept ? (NUM_REQ'(1) << gnt) : '0;
  assign mul_a      = accept ? req_a[int'(gnt)*WIDTH_A +: WIDTH_A] : '0;
  assign mul_b      = accept ? req_b[int'(gnt)*WIDTH_B +: WIDTH_B] : '0;
  assign busy       = |inflight;

  // scan from ptr upward with wrap; descending loop lets the nearest valid win
  always_comb begin
    gnt = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[wrap(int'(ptr) + k)]) gnt = wrap(int'(ptr) + k);
  end

  // priority pointer moves just past the requester that was served
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (accept) ptr <= wrap(int'(gnt) + 1);

  if (LATENCY == 0) begin : g_comb
    assign head_v  = accept;
    assign head_id = gnt;
  end else begin : g_pipe
    logic [LATENCY-1:0] tv;
    logic [ID_W-1:0]    tid [LATENCY];
    assign head_v  = tv[LATENCY-1];
    assign head_id = tid[LATENCY-1];
    // requester tags travel in lockstep with the multiplier stages
    always_ff @(posedge clk)
      if (rst) begin
        tv <= '0;
        for (int i = 0; i < LATENCY; i++) tid[i] <= '0;
      end else if (mul_pip_en) begin
        tv[0]  <= accept;
        tid[0] <= gnt;
        for (int i = 1; i < LATENCY; i++) begin
          tv[i]  <= tv[i-1];
          tid[i] <= tid[i-1];
        end
      end
  end

  // capture a tagged product, or empty the register once its result is taken
  always_ff @(posedge clk)
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else if (mul_pip_en && (head_v || resp_valid)) begin
      resp_valid <= head_v;
      resp_id    <= head_id;
      resp_data  <= mul_out;
    end

  // products owned by the block: tag pipe plus result register
  always_ff @(posedge clk)
    if (rst) inflight <= '0;
    else inflight <= inflight + CNT_W'(accept) - CNT_W'(resp_valid && resp_ready);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed checks of arbitration, latency, back-pressure and reset
module tb_mul_share_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;

  logic [3:0]  rv0 = '0, rq0, rv1 = '0, rq1;
  logic [63:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        rr0 = 1'b1, rr1 = 1'b1;
  logic        resp_v0, resp_v1, pe0, pe1, busy0, busy1;
  logic [1:0]  id0, id1;
  logic [31:0] d0, d1, mo0, mo1, s1, s2;
  logic [15:0] ma0, mb0, ma1, mb1;
  logic [1:0]  infl0;
  logic [0:0]  infl1;

  always #5 clk = ~clk;

  mul_share_arbiter #(.LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rq0), .req_a(a0), .req_b(b0),
    .resp_valid(resp_v0), .resp_ready(rr0), .resp_id(id0), .resp_data(d0),
    .mul_pip_en(pe0), .mul_a(ma0), .mul_b(mb0), .mul_out(mo0),
    .inflight(infl0), .busy(busy0));

  mul_share_arbiter #(.LATENCY(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rq1), .req_a(a1), .req_b(b1),
    .resp_valid(resp_v1), .resp_ready(rr1), .resp_id(id1), .resp_data(d1),
    .mul_pip_en(pe1), .mul_a(ma1), .mul_b(mb1), .mul_out(mo1),
    .inflight(infl1), .busy(busy1));

  always @(posedge clk)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else if (pe0) begin
      s1 <= ma0 * mb0;
      s2 <= s1;
    end
  assign mo0 = s2;
  assign mo1 = ma1 * mb1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_resp_valid", resp_v0, 0);
    chk("rst_resp_id", id0, 0);
    chk("rst_resp_data", d0, 0);
    chk("rst_inflight", infl0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_pip_en", pe0, 1);
    chk("rst_req_ready", rq0, 0);

    // single request: requester 1, 7*9
    a0[16 +: 16] = 16'd7;
    b0[16 +: 16] = 16'd9;
    rv0 = 4'b0010;
    #1;
    chk("single_ready", rq0, 4'b0010);
    chk("single_mul_a", ma0, 7);
    chk("single_mul_b", mb0, 9);
    tick();
    rv0 = '0;
    #1;
    chk("single_mul_a_idle", ma0, 0);
    chk("single_inflight1", infl0, 1);
    chk("single_valid_e0", resp_v0, 0);
    tick();
    chk("single_valid_e1", resp_v0, 0);
    tick();
    chk("single_valid_e2", resp_v0, 1);
    chk("single_id", id0, 1);
    chk("single_data", d0, 63);
    tick();
    chk("single_drained", resp_v0, 0);
    chk("single_inflight0", infl0, 0);
    chk("single_busy0", busy0, 0);

    // round-robin from ptr=0: products (i+1)*10
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a0[i*16 +: 16] = 16'(i + 1);
      b0[i*16 +: 16] = 16'd10;
    end
    rv0 = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) rv0 = '0;
      #1;
      chk("rr_grant", rq0, k < 8 ? (64'd1 << (k % 4)) : 64'd0);
      tick();
      if (k >= 2) begin
        chk("rr_valid", resp_v0, 1);
        chk("rr_id", id0, (k - 2) % 4);
        chk("rr_data", d0, ((k - 2) % 4 + 1) * 10);
      end
    end
    chk("rr_inflight_tail", infl0, 1);
    tick();
    chk("rr_drained", resp_v0, 0);
    chk("rr_inflight0", infl0, 0);

    // pointer wrap: move ptr to 3, then only 0 and 3 valid
    rv0 = 4'b0100;
    #1;
    chk("wrap_pre", rq0, 4'b0100);
    tick();
    rv0 = 4'b1001;
    #1;
    chk("wrap_g3", rq0, 4'b1000);
    tick();
    chk("wrap_g0", rq0, 4'b0001);
    tick();
    chk("wrap_g3b", rq0, 4'b1000);
    tick();
    rv0 = '0;
    repeat (4) tick();
    chk("wrap_inflight0", infl0, 0);

    // back-pressure: ids 0,1,2 with products 6,9,12
    for (int i = 0; i < 3; i++) begin
      a0[i*16 +: 16] = 16'(i + 2);
      b0[i*16 +: 16] = 16'd3;
    end
    rv0 = 4'b0111;
    repeat (3) tick();
    rv0 = 4'b1111;
    rr0 = 1'b0;
    chk("bp_first_valid", resp_v0, 1);
    chk("bp_first_id", id0, 0);
    chk("bp_inflight3", infl0, 3);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_pip_en", pe0, 0);
      chk("bp_no_ready", rq0, 0);
      tick();
      chk("bp_data_stable", d0, 6);
      chk("bp_id_stable", id0, 0);
      chk("bp_inflight_hold", infl0, 3);
    end
    rv0 = '0;
    rr0 = 1'b1;
    #1;
    chk("bp_release_en", pe0, 1);
    tick();
    chk("bp_out1_valid", resp_v0, 1);
    chk("bp_out1_id", id0, 1);
    chk("bp_out1_data", d0, 9);
    chk("bp_out1_infl", infl0, 2);
    tick();
    chk("bp_out2_valid", resp_v0, 1);
    chk("bp_out2_id", id0, 2);
    chk("bp_out2_data", d0, 12);
    tick();
    chk("bp_end_valid", resp_v0, 0);
    chk("bp_end_infl", infl0, 0);

    // reset with two products in the tag pipe
    rv0 = 4'b0011;
    repeat (2) tick();
    rv0 = '0;
    chk("mid_infl2", infl0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", resp_v0, 0);
    chk("mid_rst_infl", infl0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_no_stale", resp_v0, 0);
    end
    rv0 = 4'b1111;
    #1;
    chk("mid_ptr_reset", rq0, 4'b0001);
    rv0 = '0;

    // combinational multiplier: requester 2, 0xFFFF*2
    a1[32 +: 16] = 16'hFFFF;
    b1[32 +: 16] = 16'd2;
    rv1 = 4'b0100;
    #1;
    chk("comb_ready", rq1, 4'b0100);
    tick();
    rv1 = '0;
    chk("comb_valid", resp_v1, 1);
    chk("comb_id", id1, 2);
    chk("comb_data", d1, 32'h1FFFE);
    chk("comb_infl1", infl1, 1);
    tick();
    chk("comb_drained", resp_v1, 0);
    chk("comb_infl0", infl1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
